log2_histogram: RTL and testbench
=================================

// Module: log2_histogram
//
// PURPOSE
//   Downstream consumer of the log2 stage. Accumulates one saturating count per
//   log2 result bin (2**M bins) for samples flagged as exact powers of two, and
//   counts non-exact samples separately. On request, streams all bin counts out
//   over a valid/ready interface, optionally clearing each bin after it is read.
//
// PARAMETERS
//   M             3  Width of the incoming log2 result; bin count NB = 2**M
//   CW           16  Width of every counter (bins, miss, drop)
//   CLEAR_ON_READ 1  1: bin is zeroed when read out, miss_count is zeroed in DONE; 0: kept
//
// PORTS
//   clk          in   1   Clock, all state updates on rising edge
//   reset        in   1   Synchronous, active-high reset
//   sample_en    in   1   One sample presented this cycle
//   sample_bin   in   M   log2 result of the sample (bin index)
//   sample_exact in   1   1 = sample was an exact power of two (log2 valid flag)
//   dump_req     in   1   Start a readout of all bins (level-sampled, acted on in IDLE)
//   out_valid    out  1   out_bin/out_count hold a bin record
//   out_ready    in   1   Consumer accepts the record when out_valid && out_ready
//   out_bin      out  M   Bin index of current record
//   out_count    out  CW  Count of current record
//   miss_count   out  CW  Saturating count of non-exact samples
//   drop_count   out  CW  Saturating count of samples ignored outside IDLE
//   busy         out  1   1 in DUMP or DONE
//   done         out  1   One-cycle pulse (DONE state) after the last bin transfers
//
// BEHAVIOUR
//   Reset: state=IDLE, all bins, miss_count, drop_count, idx = 0; out_valid=0,
//     out_bin=0, out_count=0, busy=0, done=0. Reset mid-dump aborts the dump.
//   FSM states: IDLE, DUMP, DONE.
//   IDLE: sample_en && sample_exact -> bin[sample_bin] += 1, holds at 2**CW-1.
//     sample_en && !sample_exact -> miss_count += 1, saturating. sample_bin
//     ignored for non-exact samples. dump_req=1 -> DUMP next cycle with idx=0;
//     a sample in the same cycle as dump_req is still counted before the dump.
//   DUMP: out_valid=1, out_bin=idx, out_count=bin[idx], busy=1. out_valid is
//     asserted one cycle after dump_req is sampled. Record held stable while
//     out_ready=0. On transfer: if CLEAR_ON_READ, bin[idx] <= 0; if idx==NB-1
//     -> DONE, else idx += 1. One record per cycle max (back-to-back with
//     out_ready held high: NB records in NB cycles).
//   DONE: out_valid=0, done=1, busy=1 for exactly one cycle; if CLEAR_ON_READ,
//     miss_count <= 0. Next state IDLE.
//   Outside IDLE: sample_en increments drop_count (saturating) and does not
//     touch bins or miss_count. dump_req is ignored outside IDLE. drop_count is
//     cleared only by reset.
//   out_bin/out_count are 0 whenever out_valid=0.
//   All counters saturate at 2**CW-1; no wrap-around.
//
// TESTING
//   1. Reset; 5 samples bin=3 exact, 2 non-exact -> bin[3]=5, miss_count=2, others 0.
//   2. dump_req with out_ready=1 -> out_valid 1 cycle later; 8 records bin 0..7,
//      bin 3 count=5; done pulses 1 cycle after the last record; bins then 0.
//   3. Dump with out_ready toggling 1/0 -> each record held stable while stalled,
//      no record lost or repeated, bin 7 is the last record.
//   4. sample_en=1 for 4 cycles during a dump -> drop_count=4, bins unchanged.
//   5. CW=4: 20 exact samples to bin 1 -> bin[1] saturates at 15.
//   6. Assert reset during record 4 of a dump -> next cycle out_valid=0, busy=0,
//      all counters 0, state IDLE; a new dump_req restarts at bin 0.

Source files
------------

// File: rtl/log2_histogram.sv
// log2_histogram
//   Histogram of log2 results. Exact power-of-two samples bump one saturating
//   counter per bin; non-exact samples bump miss_count. A dump request streams
//   every bin (0..NB-1) out over valid/ready, optionally clearing each bin as
//   it is read and clearing miss_count once the dump completes.
//
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   sample_en/_bin/_exact      sample input (bin index + exact flag)
//   dump_req                   start a readout (acted on only in IDLE)
//   out_valid/out_ready        record handshake
//   out_bin/out_count          current record, zero while out_valid=0
//   miss_count, drop_count     non-exact samples / samples ignored outside IDLE
//   busy, done                 dump in progress / one-cycle completion pulse
module log2_histogram #(
  parameter int M             = 3,
  parameter int CW            = 16,
  parameter bit CLEAR_ON_READ = 1'b1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sample_en,
  input  logic [M-1:0]  sample_bin,
  input  logic          sample_exact,
  input  logic          dump_req,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [M-1:0]  out_bin,
  output logic [CW-1:0] out_count,
  output logic [CW-1:0] miss_count,
  output logic [CW-1:0] drop_count,
  output logic          busy,
  output logic          done
);

  localparam int NB = 2 ** M;
  localparam logic [M-1:0] LAST_IDX = {M{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DUMP = 2'd1,
    DONE = 2'd2
  } state_t;

  // Saturating increment shared by every counter.
  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == {CW{1'b1}}) ? v : v + {{(CW-1){1'b0}}, 1'b1};
  endfunction

  state_t        state_q, state_d;
  logic [M-1:0]  idx_q, idx_d;
  logic [CW-1:0] bins_q [NB];
  logic [CW-1:0] bins_d [NB];
  logic [CW-1:0] miss_q, miss_d;
  logic [CW-1:0] drop_q, drop_d;
  logic          out_valid_q, out_valid_d;
  logic [M-1:0]  out_bin_q, out_bin_d;
  logic [CW-1:0] out_count_q, out_count_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;

  // Next-state for FSM, counters and the registered output record.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    bins_d  = bins_q;
    miss_d  = miss_q;
    drop_d  = drop_q;
    case (state_q)
      IDLE: begin
        if (sample_en && sample_exact) begin
          bins_d[sample_bin] = sat_inc(bins_q[sample_bin]);
        end else if (sample_en) begin
          miss_d = sat_inc(miss_q);
        end else begin
          miss_d = miss_q;
        end
        if (dump_req) begin
          state_d = DUMP;
          idx_d   = {M{1'b0}};
        end else begin
          state_d = IDLE;
        end
      end
      DUMP: begin
        if (sample_en) begin
          drop_d = sat_inc(drop_q);
        end else begin
          drop_d = drop_q;
        end
        if (out_ready) begin
          if (CLEAR_ON_READ) begin
            bins_d[idx_q] = {CW{1'b0}};
          end else begin
            bins_d[idx_q] = bins_q[idx_q];
          end
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
          end else begin
            idx_d = idx_q + {{(M-1){1'b0}}, 1'b1};
          end
        end else begin
          state_d = DUMP;
        end
      end
      DONE: begin
        if (sample_en) begin
          drop_d = sat_inc(drop_q);
        end else begin
          drop_d = drop_q;
        end
        if (CLEAR_ON_READ) begin
          miss_d = {CW{1'b0}};
        end else begin
          miss_d = miss_q;
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Record is built from next-state bins so a sample landing in bin 0 on the
    // dump_req cycle is already reflected in the first record.
    out_valid_d = (state_d == DUMP);
    out_bin_d   = (state_d == DUMP) ? idx_d : {M{1'b0}};
    out_count_d = (state_d == DUMP) ? bins_d[idx_d] : {CW{1'b0}};
    busy_d      = (state_d != IDLE);
    done_d      = (state_d == DONE);
  end

  // State, counter and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      idx_q       <= {M{1'b0}};
      miss_q      <= {CW{1'b0}};
      drop_q      <= {CW{1'b0}};
      out_valid_q <= 1'b0;
      out_bin_q   <= {M{1'b0}};
      out_count_q <= {CW{1'b0}};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      for (int i = 0; i < NB; i++) begin
        bins_q[i] <= {CW{1'b0}};
      end
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      miss_q      <= miss_d;
      drop_q      <= drop_d;
      out_valid_q <= out_valid_d;
      out_bin_q   <= out_bin_d;
      out_count_q <= out_count_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      for (int i = 0; i < NB; i++) begin
        bins_q[i] <= bins_d[i];
      end
    end
  end

  assign out_valid  = out_valid_q;
  assign out_bin    = out_bin_q;
  assign out_count  = out_count_q;
  assign miss_count = miss_q;
  assign drop_count = drop_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_log2_histogram.sv
// tb_log2_histogram
//   Drives two instances from the same stimulus: A (CW=16, clear-on-read) and
//   B (CW=4, no clear). A behavioural model of each histogram predicts every
//   output each cycle; directed literal checks pin the model's key results.
module tb_log2_histogram;

  logic        clk = 1'b0;
  logic        reset;
  logic        sample_en, sample_exact, dump_req, out_ready;
  logic [2:0]  sample_bin;

  logic        a_ov, a_busy, a_done;
  logic [2:0]  a_bin;
  logic [15:0] a_cnt, a_miss, a_drop;
  logic        b_ov, b_busy, b_done;
  logic [2:0]  b_bin;
  logic [3:0]  b_cnt, b_miss, b_drop;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  log2_histogram #(.M(3), .CW(16), .CLEAR_ON_READ(1'b1)) u_a (
    .clk(clk), .reset(reset), .sample_en(sample_en), .sample_bin(sample_bin),
    .sample_exact(sample_exact), .dump_req(dump_req), .out_valid(a_ov),
    .out_ready(out_ready), .out_bin(a_bin), .out_count(a_cnt),
    .miss_count(a_miss), .drop_count(a_drop), .busy(a_busy), .done(a_done));

  log2_histogram #(.M(3), .CW(4), .CLEAR_ON_READ(1'b0)) u_b (
    .clk(clk), .reset(reset), .sample_en(sample_en), .sample_bin(sample_bin),
    .sample_exact(sample_exact), .dump_req(dump_req), .out_valid(b_ov),
    .out_ready(out_ready), .out_bin(b_bin), .out_count(b_cnt),
    .miss_count(b_miss), .drop_count(b_drop), .busy(b_busy), .done(b_done));

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int mb[2][8];
  int mmiss[2], mdrop[2], mpos[2];
  bit mdump[2], mdone[2];
  bit mvalid = 1'b0;
  int smax[2] = '{65535, 15};
  bit clr[2]  = '{1'b1, 1'b0};

  always @(posedge clk) begin
    if (reset) begin
      mvalid = 1'b1;
      for (int k = 0; k < 2; k++) begin
        for (int j = 0; j < 8; j++) mb[k][j] = 0;
        mmiss[k] = 0; mdrop[k] = 0; mpos[k] = 0;
        mdump[k] = 1'b0; mdone[k] = 1'b0;
      end
    end else if (mvalid) begin
      for (int k = 0; k < 2; k++) begin
        if (mdone[k]) begin
          if (sample_en && mdrop[k] < smax[k]) mdrop[k]++;
          if (clr[k]) mmiss[k] = 0;
          mdone[k] = 1'b0;
        end else if (mdump[k]) begin
          if (sample_en && mdrop[k] < smax[k]) mdrop[k]++;
          if (out_ready) begin
            if (clr[k]) mb[k][mpos[k]] = 0;
            if (mpos[k] == 7) begin
              mdump[k] = 1'b0;
              mdone[k] = 1'b1;
            end else begin
              mpos[k]++;
            end
          end
        end else begin
          if (sample_en && sample_exact && mb[k][sample_bin] < smax[k]) mb[k][sample_bin]++;
          if (sample_en && !sample_exact && mmiss[k] < smax[k]) mmiss[k]++;
          if (dump_req) begin
            mdump[k] = 1'b1;
            mpos[k] = 0;
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (mvalid) begin
      chk("A_valid", a_ov, mdump[0]);
      chk("A_bin", a_bin, mdump[0] ? mpos[0] : 0);
      chk("A_count", a_cnt, mdump[0] ? mb[0][mpos[0]] : 0);
      chk("A_miss", a_miss, mmiss[0]);
      chk("A_drop", a_drop, mdrop[0]);
      chk("A_busy", a_busy, mdump[0] || mdone[0]);
      chk("A_done", a_done, mdone[0]);
      chk("B_valid", b_ov, mdump[1]);
      chk("B_bin", b_bin, mdump[1] ? mpos[1] : 0);
      chk("B_count", b_cnt, mdump[1] ? mb[1][mpos[1]] : 0);
      chk("B_miss", b_miss, mmiss[1]);
      chk("B_drop", b_drop, mdrop[1]);
      chk("B_busy", b_busy, mdump[1] || mdone[1]);
      chk("B_done", b_done, mdone[1]);
    end
  end

  // Transferred records, logged for the directed literal checks.
  int qa_bin[$], qa_cnt[$], qb_bin[$], qb_cnt[$];
  always @(negedge clk) begin
    if (mvalid && !reset && out_ready) begin
      if (a_ov) begin qa_bin.push_back(int'(a_bin)); qa_cnt.push_back(int'(a_cnt)); end
      if (b_ov) begin qb_bin.push_back(int'(b_bin)); qb_cnt.push_back(int'(b_cnt)); end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_q();
    qa_bin.delete(); qa_cnt.delete(); qb_bin.delete(); qb_cnt.delete();
  endtask

  task automatic wait_done(input string name, input int budget);
    int n;
    n = 0;
    while (!a_done && n < budget) begin
      tick();
      n++;
    end
    chk(name, a_done, 1);
  endtask

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  initial begin
    int found;
    int sum;
    reset = 1'b1; sample_en = 1'b0; sample_bin = 3'd0; sample_exact = 1'b0;
    dump_req = 1'b0; out_ready = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_valid", a_ov, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_drop", a_drop, 0);

    // 5 exact samples to bin 3, 2 non-exact samples
    for (int i = 0; i < 5; i++) begin
      sample_en = 1'b1; sample_exact = 1'b1; sample_bin = 3'd3; tick();
    end
    for (int i = 0; i < 2; i++) begin
      sample_en = 1'b1; sample_exact = 1'b0; sample_bin = 3'($urandom_range(7)); tick();
    end
    sample_en = 1'b0; tick();
    chk("t1_miss_A", a_miss, 2);
    chk("t1_miss_B", b_miss, 2);

    // Full-speed dump
    clear_q();
    out_ready = 1'b1; dump_req = 1'b1; tick(); dump_req = 1'b0;
    chk("t2_latency", a_ov, 1);
    chk("t2_first_bin", a_bin, 0);
    wait_done("t2_done", 20);
    chk("t2_nrec", qa_bin.size(), 8);
    chk("t2_bin3", qget(qa_cnt, 3), 5);
    chk("t2_last", qget(qa_bin, 7), 7);
    tick();
    chk("t2_pulse", a_done, 0);
    chk("t2_idle", a_busy, 0);
    chk("t2_missclr_A", a_miss, 0);
    chk("t2_misskeep_B", b_miss, 2);

    // Stalled dump with samples dropped during it
    clear_q();
    out_ready = 1'b0; dump_req = 1'b1; tick(); dump_req = 1'b0;
    found = 0;
    for (int i = 0; i < 60 && !a_done; i++) begin
      out_ready = (i % 2) == 1;
      sample_en = (i < 4); sample_exact = 1'b1; sample_bin = 3'd5;
      tick();
      found++;
    end
    sample_en = 1'b0;
    chk("t3_done", a_done, 1);
    chk("t3_nrec", qa_bin.size(), 8);
    for (int j = 0; j < 8; j++) chk("t3_order", qget(qa_bin, j), j);
    sum = 0;
    foreach (qa_cnt[j]) sum += qa_cnt[j];
    chk("t3_cleared", sum, 0);
    chk("t4_drop_A", a_drop, 4);
    chk("t4_drop_B", b_drop, 4);
    chk("t4_bin3_B", qget(qb_cnt, 3), 5);
    tick();

    // Saturation on the 4-bit instance
    for (int i = 0; i < 20; i++) begin
      sample_en = 1'b1; sample_exact = 1'b1; sample_bin = 3'd1; tick();
    end
    sample_en = 1'b0;
    clear_q();
    out_ready = 1'b1; dump_req = 1'b1; tick(); dump_req = 1'b0;
    wait_done("t5_done", 20);
    chk("t5_sat_B", qget(qb_cnt, 1), 15);
    chk("t5_nosat_A", qget(qa_cnt, 1), 20);
    tick();

    // Reset during record 4
    clear_q();
    out_ready = 1'b1; dump_req = 1'b1; tick(); dump_req = 1'b0;
    found = 0;
    for (int i = 0; i < 20 && found == 0; i++) begin
      if (a_ov && a_bin == 3'd4) found = 1;
      else tick();
    end
    chk("t6_rec4", found, 1);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("t6_valid", a_ov, 0);
    chk("t6_busy", a_busy, 0);
    chk("t6_drop", a_drop, 0);
    chk("t6_miss_B", b_miss, 0);
    clear_q();
    dump_req = 1'b1; tick(); dump_req = 1'b0;
    wait_done("t6_redone", 20);
    chk("t6_restart", qget(qa_bin, 0), 0);
    chk("t6_nrec", qa_bin.size(), 8);
    tick();

    // Randomised traffic checked by the model every cycle
    for (int i = 0; i < 3000; i++) begin
      reset        = ($urandom_range(499) == 0);
      sample_en    = $urandom_range(1) == 1;
      sample_exact = $urandom_range(3) != 0;
      sample_bin   = 3'($urandom_range(7));
      dump_req     = $urandom_range(19) == 0;
      out_ready    = $urandom_range(2) != 0;
      tick();
    end
    reset = 1'b0; sample_en = 1'b0; dump_req = 1'b0;
    tick(); tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
